// File: rtl/samul_pkg.sv
// Shared types and constants for the arbitrated iterative multiplier.
// The FSM encoding, the default operand width and the response latency live here.
package samul_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int LATENCY   = WIDTH_DEF + 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/samul_iter_core.sv
// Sign-magnitude shift-add multiplier datapath: magnitudes in M/Q, partial sum in C,
// one add-and-shift per step, sign re-applied combinationally on the final product.
module samul_iter_core
    import samul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   prod_o
);

    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     c_q, c_d;
    logic               sign_q, sign_d;
    logic [WIDTH:0]     acc_s;
    logic [2*WIDTH-1:0] full_s;

    // Unsigned magnitude; the most negative operand maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state of the datapath registers: load, step or hold.
    always_comb begin
        m_d    = m_q;
        q_d    = q_q;
        c_d    = c_q;
        sign_d = sign_q;
        acc_s  = q_q[0] ? (c_q + {1'b0, m_q}) : c_q;
        if (load_i) begin
            m_d    = abs_val(a_i);
            q_d    = abs_val(b_i);
            c_d    = {(WIDTH+1){1'b0}};
            sign_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end else if (step_i) begin
            c_d = {1'b0, acc_s[WIDTH:1]};
            q_d = {acc_s[0], q_q[WIDTH-1:1]};
        end else begin
            c_d = c_q;
        end
    end

    // Datapath register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= {WIDTH{1'b0}};
            q_q    <= {WIDTH{1'b0}};
            c_q    <= {(WIDTH+1){1'b0}};
            sign_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            q_q    <= q_d;
            c_q    <= c_d;
            sign_q <= sign_d;
        end
    end

    // C never exceeds WIDTH bits after a shift, so the product is {C[WIDTH-1:0], Q}.
    assign full_s = {c_q[WIDTH-1:0], q_q};
    assign prod_o = sign_q ? (~full_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : full_s;

endmodule

// File: rtl/samul_arb_ctrl.sv
// Round-robin front end that shares one iterative multiplier between two requesters;
// holds the FSM, arbiter, step counter and the registered response.
module samul_arb_ctrl
    import samul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic               grant_vld_s, grant_id_s;
    logic               load_s, step_s;
    logic [2*WIDTH-1:0] prod_s;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        grant_vld_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_q;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // FSM next-state and datapath controls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_d = ST_LOAD;
                    last_d  = grant_id_s;
                    id_d    = grant_id_s;
                    a_d     = grant_id_s ? req1_a : req0_a;
                    b_d     = grant_id_s ? req1_b : req0_b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s  = 1'b1;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_ITER;
            end
            ST_ITER: begin
                step_s = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_SIGN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SIGN: begin
                rsp_result_d = prod_s;
                rsp_id_d     = id_q;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    samul_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .step_i (step_s),
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_o (prod_s)
    );

    assign req0_ready = (state_q == ST_IDLE) && grant_vld_s && !grant_id_s;
    assign req1_ready = (state_q == ST_IDLE) && grant_vld_s &&  grant_id_s;
    assign rsp_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: doc/samul_arb_ctrl.md
SAMUL_ARB_CTRL -- requirements
Module: samul_arb_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; the result is 2*WIDTH bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 has an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  signed two's-complement operands.
REQ-007 req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-008 rsp_valid  output  1  product available.
REQ-009 rsp_ready  input  1  consumer takes the product.
REQ-010 rsp_id  output  1  requester that owns the product.
REQ-011 rsp_result  output  2*WIDTH  signed product.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL share one iterative sign-magnitude shift-add multiplier between two requesters.
REQ-014 FSM states: IDLE, LOAD, ITER, SIGN, DONE.
REQ-015 IDLE: with any reqN_valid high, grant one requester, assert its reqN_ready combinationally, capture its operands and ID at the edge, then go to LOAD.
REQ-016 reqN_ready SHALL be low outside IDLE and is never high for both requesters in the same cycle.
REQ-017 Arbitration is round-robin: with both valid, grant the requester not granted last; the last-grant register resets to 1, so requester 0 wins the first tie.
REQ-018 Requesters hold valid and operands stable until ready; the block does not check this.
REQ-019 LOAD: register M = |a| and Q = |b| as WIDTH-bit unsigned values; clear the WIDTH+1-bit accumulator C; store sign = a[MSB] XOR b[MSB].
REQ-020 ITER: each edge does one step (if Q[0], C += M; then shift {C,Q} right by 1); a counter runs 0..WIDTH-1; after WIDTH steps go to SIGN.
REQ-021 SIGN: rsp_result <= sign ? two's-complement negation of {C,Q}[2*WIDTH-1:0] : {C,Q}[2*WIDTH-1:0]; go to DONE.
REQ-022 DONE: rsp_valid is high, and rsp_result and rsp_id stay stable until rsp_valid && rsp_ready; on that edge go to IDLE.
REQ-023 Latency SHALL be exactly WIDTH+3 rising edges from the accepting edge to the first cycle with rsp_valid high (35 for WIDTH=32).
REQ-024 There is no same-cycle bypass from DONE to a new accept; the next grant occurs in IDLE at the earliest one cycle after the response handshake.
REQ-025 Operand -2^(WIDTH-1) SHALL yield magnitude 2^(WIDTH-1) without overflow; a zero product with sign=1 SHALL output 0.
REQ-026 Requests that arrive while busy stay pending and are arbitrated on return to IDLE.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, counter 0, last-grant 1, req0_ready/req1_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, busy 0.
REQ-028 Reset in any state, including mid-ITER, aborts the operation; no response is produced for it.

Structure
REQ-029 Package samul_pkg SHALL hold the FSM state encoding, the WIDTH default and the LATENCY = WIDTH+3 constant.
REQ-030 The iterative datapath (M, C, Q registers, sign, step, final negation) SHALL be sub-module samul_iter_core.
REQ-031 samul_arb_ctrl SHALL keep the FSM, the arbiter, the step counter and the response registers.

Verification
REQ-032 req0 a=7, b=-3, rsp_ready=1 -> rsp_valid exactly 35 edges after accept; rsp_id=0; rsp_result=64'hFFFF_FFFF_FFFF_FFEB.
REQ-033 req1 a=b=32'h8000_0000 -> rsp_id=1, rsp_result=64'h4000_0000_0000_0000; a=b=-1 -> 64'h1; a=0, b=-5 -> 64'h0.
REQ-034 Both valid in the first cycle after reset -> req0 served first, then req1; rsp_id sequence 0,1; req0_ready and req1_ready never high together.
REQ-035 rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_id and rsp_result stable; both reqN_ready stay 0; IDLE is entered on the edge rsp_ready is sampled high.
REQ-036 rst_n pulsed low during ITER step 10 -> all outputs go to reset values at once; no rsp_valid follows; the next request completes with a correct product.
